// File: rtl/majority_sweep_ctrl_if.sv
// Bundle of the board-side controls and the DUT-facing vector/result signals
// for the majority sweep controller. The master side drives the controls and
// the DUT result. The slave side is the controller.
interface majority_sweep_ctrl_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic             step_mode;
    logic             step;
    logic             dut_out;
    logic [WIDTH-1:0] dut_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       err_count;
    logic [WIDTH-1:0] first_fail;

    modport master (
        output start, step_mode, step, dut_out,
        input  dut_in, busy, done, pass, err_count, first_fail
    );

    modport slave (
        input  start, step_mode, step, dut_out,
        output dut_in, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/majority_sweep_ctrl.sv
// Self-test sequencer for a combinational majority DUT. It walks dut_in through
// every vector once and holds each vector for a dwell time. In auto mode the
// dwell ends on a timeout, and in step mode it ends on a step edge. At the end
// of each dwell it compares dut_out with a golden majority. It reports an error
// count that saturates, the first failing vector and the pass/done status.
module majority_sweep_ctrl #(
    parameter int WIDTH = 3,
    parameter int DWELL = 50_000_000,
    parameter int CNT_W = 26
) (
    input logic                  MAX10_CLK1_50,
    input logic                  reset,
    majority_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
    localparam logic [WIDTH-1:0] LAST_VEC = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dut_in_q, dut_in_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       err_q, err_d;
    logic [WIDTH-1:0] ff_q, ff_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             start_q, step_q;

    logic start_rise, step_rise, golden;

    assign start_rise = bus.start & ~start_q;
    assign step_rise  = bus.step & ~step_q;
    assign golden     = ($countones(dut_in_q) > (WIDTH / 2));

    // Next-state and next-output logic for the sweep FSM
    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ff_d     = ff_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        case (state_q)
            // A new sweep can start from IDLE or DONE. While busy, start is ignored.
            IDLE, DONE: begin
                if (start_rise) begin
                    state_d  = SETTLE;
                    dut_in_d = '0;
                    cnt_d    = '0;
                    err_d    = '0;
                    ff_d     = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            SETTLE: begin
                if (bus.step_mode) begin
                    // The counter is frozen in step mode, so a later switch
                    // to auto mode continues from the same count.
                    if (step_rise) state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Use >= so that a counter left past the limit still samples.
                    if (cnt_q >= DWELL_M1) state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (bus.dut_out != golden) begin
                    if (err_q != 4'hF) err_d = err_q + 4'd1;
                    if (err_q == 4'd0) ff_d = dut_in_q;
                end
                if (dut_in_q == LAST_VEC) begin
                    // Keep the last vector on dut_in. There is no wrap back to 0.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 4'd0);
                end else begin
                    state_d  = SETTLE;
                    dut_in_d = dut_in_q + WIDTH'(1);
                    cnt_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, output and edge-detect registers. An asynchronous reset clears all of them.
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dut_in_q <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            ff_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            start_q  <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            start_q  <= bus.start;
            step_q   <= bus.step;
        end
    end

    assign bus.dut_in     = dut_in_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
endmodule

// File: tb/tb_majority_sweep_ctrl.sv
// Scoreboard bench for majority_sweep_ctrl with WIDTH=3 and DWELL=4. The
// emulated DUT is the true majority XOR a per-vector fault mask. Each sweep
// pushes the expected result into a queue, and a monitor checks it when done rises.
module tb_majority_sweep_ctrl;
    logic clk, rst;
    logic [7:0] mask;
    int tests, fails, cyc, start_cyc, sweeps_seen;

    typedef struct {
        int err;
        int ff;
        int pass;
        int lat;
    } exp_t;
    exp_t sb[$];

    majority_sweep_ctrl_if #(.WIDTH(3)) bus();

    majority_sweep_ctrl #(.WIDTH(3), .DWELL(4), .CNT_W(3)) dut (
        .MAX10_CLK1_50 (clk),
        .reset         (rst),
        .bus           (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Emulated DUT: a vector whose mask bit is set gives a wrong answer.
    always_comb begin
        bus.dut_out = (($countones(bus.dut_in) >= 2) ? 1'b1 : 1'b0) ^ mask[bus.dut_in];
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: one sample per vector, so the errors are the set bits of the mask.
    function automatic exp_t model(input logic [7:0] m, input int lat);
        exp_t e;
        int n;
        n = $countones(m);
        e.err = (n > 15) ? 15 : n;
        e.ff = 0;
        for (int v = 7; v >= 0; v--) if (m[v]) e.ff = v;
        e.pass = (m == 8'h00) ? 1 : 0;
        e.lat = lat;
        return e;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_cleared();
        chk("start_busy", int'(bus.busy), 1);
        chk("start_done", int'(bus.done), 0);
        chk("start_pass", int'(bus.pass), 0);
        chk("start_err", int'(bus.err_count), 0);
        chk("start_dut_in", int'(bus.dut_in), 0);
    endtask

    task automatic wait_sweep(input int target, input bit rnd_step, input bit restart_mid);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sweeps_seen >= target) begin
                got = 1'b1;
                break;
            end
            if (rnd_step) bus.step = 1'($urandom_range(0, 1));
            if (restart_mid) bus.start = (i == 12 || i == 25) ? 1'b1 : 1'b0;
        end
        bus.step  = 1'b0;
        bus.start = 1'b0;
        if (!got) chk("sweep_timeout", 0, 1);
    endtask

    task automatic run_auto(input logic [7:0] m, input bit restart_mid);
        int target;
        target = sweeps_seen + 1;
        mask = m;
        sb.push_back(model(m, 41));
        pulse_start();
        check_cleared();
        wait_sweep(target, 1'b1, restart_mid);
    endtask

    initial begin
        logic prev_done;
        bit got;
        int target;
        tests = 0; fails = 0; cyc = 0; sweeps_seen = 0; start_cyc = 0;
        mask = 8'h00;
        bus.start = 1'b0; bus.step = 1'b0; bus.step_mode = 1'b0;
        rst = 1'b1;

        // Monitor: pops one expectation on each rising edge of done.
        fork
            begin
                exp_t e;
                prev_done = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst && bus.done && !prev_done) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_done", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("err_count", int'(bus.err_count), e.err);
                            chk("first_fail", int'(bus.first_fail), e.ff);
                            chk("pass", int'(bus.pass), e.pass);
                            chk("dut_in_final", int'(bus.dut_in), 7);
                            chk("busy_final", int'(bus.busy), 0);
                            if (e.lat >= 0) chk("latency", cyc - start_cyc, e.lat);
                        end
                        sweeps_seen++;
                    end
                    prev_done = bus.done;
                end
            end
        join_none

        #5;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_pass", int'(bus.pass), 0);
        chk("rst_err", int'(bus.err_count), 0);
        chk("rst_ff", int'(bus.first_fail), 0);
        chk("rst_dut_in", int'(bus.dut_in), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ideal DUT, then stuck-at-0, then inverted majority.
        run_auto(8'h00, 1'b0);
        run_auto(8'hE8, 1'b0);
        // A restart from DONE with err_count == 4 is checked by check_cleared.
        run_auto(8'hFF, 1'b1);

        // Random fault masks. Odd sweeps also pulse start mid-sweep.
        for (int i = 0; i < 6; i++) run_auto(8'($urandom), i[0]);

        // Step mode. start and step rise together, so that step is discarded.
        mask = 8'($urandom);
        target = sweeps_seen + 1;
        sb.push_back(model(mask, -1));
        bus.step_mode = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.step = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.step = 1'b0;
        repeat (100) @(negedge clk);
        chk("step_hold_dut_in", int'(bus.dut_in), 0);
        chk("step_hold_busy", int'(bus.busy), 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk) bus.step = 1'b1;
            @(negedge clk) bus.step = 1'b0;
            repeat (3) @(negedge clk);
            if (k < 7) chk("step_advance", int'(bus.dut_in), k + 1);
        end
        wait_sweep(target, 1'b0, 1'b0);
        bus.step_mode = 1'b0;

        // Reset mid-sweep while dut_in == 5 and one error has been seen at vector 2.
        mask = 8'h04;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.dut_in == 3'd5) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_vec5", int'(got), 1);
        chk("pre_rst_err", int'(bus.err_count), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_err", int'(bus.err_count), 0);
        chk("mid_rst_ff", int'(bus.first_fail), 0);
        chk("mid_rst_dut_in", int'(bus.dut_in), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_idle_busy", int'(bus.busy), 0);
        chk("post_rst_idle_dut_in", int'(bus.dut_in), 0);

        // A full sweep from IDLE after the reset.
        run_auto(8'h81, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
